timer_counter_psc: RTL and testbench
====================================

// Module: timer_counter_psc
// PURPOSE
//  Next-generation timer counter with a parametrised width and a built-in power-of-two prescaler.
//  It adds auto-reload and one-shot modes, plus a compare-match pulse.
//  It sits between the timer register file (mode/value/control registers) and the interrupt flag logic.
//  All logic runs on PCLK; the prescaler replaces any external slow-clock input.
// PARAMETERS
//  DATA_WIDTH  8  counter, reload and compare width
//  PSC_SEL_W   3  prescaler select width; divide ratio = 2**psc_sel, range 1..2**(2**PSC_SEL_W-1)
// PORTS
//  PCLK               in   1           sole clock; all state updates on rising edge
//  PRESET_n           in   1           synchronous, active-low reset, sampled on rising PCLK
//  count_enable       in   1           1 = prescaler and counter run; 0 = hold count, clear prescaler
//  count_load         in   1           load reload_value into counter (level, acts every cycle it is 1)
//  count_up_down      in   1           0 = up, 1 = down
//  mode               in   2           00 free-run, 01 auto-reload, 10 one-shot, 11 = free-run
//  psc_sel            in   PSC_SEL_W   prescaler exponent
//  reload_value       in   DATA_WIDTH  load / reload value
//  compare_value      in   DATA_WIDTH  compare-match value
//  TCNT_Out           out  DATA_WIDTH  counter value (registered)
//  Set_OVF_pulse      out  1           1-cycle pulse on up-count terminal event
//  Set_UDF_pulse      out  1           1-cycle pulse on down-count terminal event
//  Set_CMP_pulse      out  1           1-cycle pulse on compare match
//  running            out  1           counter advancing on ticks
// BEHAVIOUR
//  Reset: TCNT_Out=0, all pulses=0, psc_cnt=0, armed=0.
//  Prescaler:
//   - psc_cnt is (2**PSC_SEL_W-1) bits wide and increments every PCLK while count_enable=1.
//   - tick is combinational: tick = count_enable & ((psc_cnt & mask)==mask), with mask = (1<<psc_sel)-1.
//   - psc_sel=0 gives a tick every cycle; psc_sel=k gives a tick every 2**k cycles.
//   - psc_cnt clears when count_enable=0 or count_load=1.
//   - A psc_sel change applies on the next cycle; psc_cnt is not cleared by it.
//  Priority: reset > count_load > tick.
//  count_load: TCNT_Out<=reload_value, armed<=1, no pulses; this happens even if count_enable=0.
//  Tick with advance allowed (mode!=10 or armed=1); terminal = TCNT_Out==max (up) or ==0 (down):
//   - non-terminal: TCNT_Out +/- 1.
//   - terminal, up: assert Set_OVF_pulse; next value = 0 (free-run) or reload_value (01, 10).
//   - terminal, down: assert Set_UDF_pulse; next value = max (free-run) or reload_value (01, 10).
//   - one-shot terminal additionally clears armed; the counter then holds the reload_value until the next count_load.
//  Set_CMP_pulse: asserted when a tick-driven update produces next value == compare_value.
//   - Wrap and reload destinations are included; count_load never raises CMP.
//   - CMP and OVF/UDF may assert in the same cycle.
//  Latency: pulses and the new TCNT_Out appear together, one PCLK after the tick cycle. Pulses self-clear the next cycle.
//  running = count_enable & (mode!=10 | armed).
//  Edge cases:
//   - reload_value==max, up, auto-reload: OVF on every tick.
//   - reload_value==0, down, auto-reload: UDF on every tick.
//   - count_up_down change: applies on the next tick; no pulse by itself.
//   - mode change mid-count: applies on the next tick. armed is retained when leaving one-shot and unchanged otherwise.
//   - PRESET_n low mid-count: everything returns to reset values on that edge, regardless of other inputs.
// STRUCTURE
//  Shared package timer_pkg:
//   - TMR_MODE_FREE=2'b00, TMR_MODE_RELOAD=2'b01, TMR_MODE_ONESHOT=2'b10
//   - TMR_DIR_UP=1'b0, TMR_DIR_DOWN=1'b1
//  Sub-module timer_prescaler (PSC_SEL_W): psc_cnt register plus tick decode; inputs enable, clear, psc_sel.
//  The top level holds the counter, the armed flag, terminal/compare decode and the pulse registers.
// TESTING
//  1. DATA_WIDTH=8, psc_sel=2, free-run up from load 8'hFD: ticks every 4 PCLK.
//     Expect FE, FF, 00 with OVF coincident with 00, then 01.
//  2. Auto-reload down, reload=8'h03, psc_sel=0.
//     Expect 03, 02, 01, 00, then 03 with UDF, repeating every 4 cycles.
//  3. One-shot up, reload=8'hFE, psc_sel=0.
//     Expect FF, then FE with OVF; running falls to 0 and TCNT holds FE.
//     A count_load re-arms it and counting resumes.
//  4. compare=8'h00, free-run up through FF->00: CMP and OVF in the same cycle. A count_load of 8'h00 gives no CMP.
//  5. count_enable dropped for 10 cycles mid-count: TCNT holds and psc_cnt clears.
//     On re-enable with psc_sel=3, the first tick comes 8 cycles later.
//  6. PRESET_n low during a one-shot run with OVF pending: all outputs 0 next edge, armed=0, running=0 in mode 10.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared constants and types for the prescaled timer family.
package timer_pkg;
  localparam logic [1:0] TMR_MODE_FREE    = 2'b00;
  localparam logic [1:0] TMR_MODE_RELOAD  = 2'b01;
  localparam logic [1:0] TMR_MODE_ONESHOT = 2'b10;

  localparam logic TMR_DIR_UP   = 1'b0;
  localparam logic TMR_DIR_DOWN = 1'b1;

  typedef struct packed {
    logic ovf;
    logic udf;
    logic cmp;
  } tmr_evt_t;
endpackage

// File: rtl/timer_prescaler.sv
// Power-of-two prescaler: free-running count with a combinational tick
// whenever the low psc_sel bits are all ones.
module timer_prescaler #(
  parameter int PSC_SEL_W = 3
) (
  input  logic                 PCLK,
  input  logic                 PRESET_n,
  input  logic                 enable_i,
  input  logic                 clear_i,
  input  logic [PSC_SEL_W-1:0] psc_sel_i,
  output logic                 tick_o
);
  localparam int CNT_W = 2**PSC_SEL_W - 1;

  logic [CNT_W-1:0] psc_cnt_q, psc_cnt_d, mask;
  logic [CNT_W:0]   mask_full;

  // One extra bit so psc_sel at its maximum still forms an all-ones mask.
  assign mask_full = ((CNT_W+1)'(1) << psc_sel_i) - (CNT_W+1)'(1);
  assign mask      = mask_full[CNT_W-1:0];
  assign tick_o    = enable_i & ((psc_cnt_q & mask) == mask);

  always_comb begin
    psc_cnt_d = psc_cnt_q + CNT_W'(1);
    if (clear_i || !enable_i) psc_cnt_d = '0;
  end

  always_ff @(posedge PCLK) begin
    if (!PRESET_n) psc_cnt_q <= '0;
    else           psc_cnt_q <= psc_cnt_d;
  end
endmodule

// File: rtl/timer_counter_psc.sv
// Up/down timer with free-run, auto-reload and one-shot modes, registered
// terminal/compare pulses, driven by the internal prescaler tick.
module timer_counter_psc
  import timer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PSC_SEL_W  = 3
) (
  input  logic                  PCLK,
  input  logic                  PRESET_n,
  input  logic                  count_enable,
  input  logic                  count_load,
  input  logic                  count_up_down,
  input  logic [1:0]            mode,
  input  logic [PSC_SEL_W-1:0]  psc_sel,
  input  logic [DATA_WIDTH-1:0] reload_value,
  input  logic [DATA_WIDTH-1:0] compare_value,
  output logic [DATA_WIDTH-1:0] TCNT_Out,
  output logic                  Set_OVF_pulse,
  output logic                  Set_UDF_pulse,
  output logic                  Set_CMP_pulse,
  output logic                  running
);
  localparam logic [DATA_WIDTH-1:0] CNT_MAX = '1;

  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic                  armed_q, armed_d;
  tmr_evt_t              evt_q, evt_d;
  logic                  tick, advance, wrap_free, oneshot;

  timer_prescaler #(.PSC_SEL_W(PSC_SEL_W)) u_psc (
    .PCLK      (PCLK),
    .PRESET_n  (PRESET_n),
    .enable_i  (count_enable),
    .clear_i   (count_load),
    .psc_sel_i (psc_sel),
    .tick_o    (tick)
  );

  assign oneshot   = (mode == TMR_MODE_ONESHOT);
  // Mode 11 behaves as free-run.
  assign wrap_free = (mode != TMR_MODE_RELOAD) && !oneshot;
  assign advance   = !oneshot || armed_q;

  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    evt_d   = '0;
    if (count_load) begin
      cnt_d   = reload_value;
      armed_d = 1'b1;
    end else if (tick && advance) begin
      if (count_up_down == TMR_DIR_UP) begin
        if (cnt_q == CNT_MAX) begin
          evt_d.ovf = 1'b1;
          cnt_d     = wrap_free ? '0 : reload_value;
          if (oneshot) armed_d = 1'b0;
        end else begin
          cnt_d = cnt_q + DATA_WIDTH'(1);
        end
      end else begin
        if (cnt_q == '0) begin
          evt_d.udf = 1'b1;
          cnt_d     = wrap_free ? CNT_MAX : reload_value;
          if (oneshot) armed_d = 1'b0;
        end else begin
          cnt_d = cnt_q - DATA_WIDTH'(1);
        end
      end
      evt_d.cmp = (cnt_d == compare_value);
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESET_n) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
      evt_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      evt_q   <= evt_d;
    end
  end

  assign TCNT_Out      = cnt_q;
  assign Set_OVF_pulse = evt_q.ovf;
  assign Set_UDF_pulse = evt_q.udf;
  assign Set_CMP_pulse = evt_q.cmp;
  assign running       = count_enable & advance;
endmodule

// File: tb/tb_timer_counter_psc.sv
// Directed bench: stimulus queues expected output events (cycle, value,
// pulses); a negedge monitor pops and compares on every observed event.
module tb_timer_counter_psc;
  logic       PCLK, PRESET_n;
  logic       count_enable, count_load, count_up_down;
  logic [1:0] mode;
  logic [2:0] psc_sel;
  logic [7:0] reload_value, compare_value, TCNT_Out;
  logic       Set_OVF_pulse, Set_UDF_pulse, Set_CMP_pulse, running;

  timer_counter_psc #(.DATA_WIDTH(8), .PSC_SEL_W(3)) dut (
    .PCLK(PCLK), .PRESET_n(PRESET_n), .count_enable(count_enable),
    .count_load(count_load), .count_up_down(count_up_down), .mode(mode),
    .psc_sel(psc_sel), .reload_value(reload_value), .compare_value(compare_value),
    .TCNT_Out(TCNT_Out), .Set_OVF_pulse(Set_OVF_pulse), .Set_UDF_pulse(Set_UDF_pulse),
    .Set_CMP_pulse(Set_CMP_pulse), .running(running)
  );

  typedef struct {
    int         cyc;
    logic [7:0] v;
    logic       o, u, c;
  } ev_t;

  ev_t        q[$];
  int         cyc = 0;
  int         n_cmp = 0, n_bad = 0;
  bit         mon_en = 0;
  logic [7:0] prev = '0;

  initial PCLK = 0;
  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  // Event = counter value changed or any pulse high.
  always @(negedge PCLK) begin
    if (mon_en && (TCNT_Out != prev || Set_OVF_pulse || Set_UDF_pulse || Set_CMP_pulse)) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event: cyc=%0d tcnt=%h ovf/udf/cmp=%b%b%b, required none",
                 cyc, TCNT_Out, Set_OVF_pulse, Set_UDF_pulse, Set_CMP_pulse);
      end else begin
        ev_t e;
        e = q.pop_front();
        if (e.cyc != cyc || e.v !== TCNT_Out || e.o !== Set_OVF_pulse ||
            e.u !== Set_UDF_pulse || e.c !== Set_CMP_pulse) begin
          n_bad++;
          $display("FAIL event: got cyc=%0d tcnt=%h ovf/udf/cmp=%b%b%b, required cyc=%0d tcnt=%h ovf/udf/cmp=%b%b%b",
                   cyc, TCNT_Out, Set_OVF_pulse, Set_UDF_pulse, Set_CMP_pulse,
                   e.cyc, e.v, e.o, e.u, e.c);
        end
      end
    end
    prev = TCNT_Out;
  end

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic push(input int c, input logic [7:0] v, input logic o, input logic u, input logic cm);
    ev_t e;
    e.cyc = c; e.v = v; e.o = o; e.u = u; e.c = cm;
    q.push_back(e);
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge PCLK);
  endtask

  // Called at a negedge; the load lands on the next posedge.
  task automatic do_load();
    count_load = 1;
    @(negedge PCLK);
    count_load = 0;
  endtask

  task automatic drain(input string name);
    @(negedge PCLK);
    @(negedge PCLK);
    chk(name, q.size(), 0);
    q.delete();
  endtask

  int b, r;

  initial begin
    PRESET_n = 0; count_enable = 0; count_load = 0; count_up_down = 0;
    mode = 2'b00; psc_sel = 0; reload_value = 0; compare_value = 8'h80;
    repeat (3) @(negedge PCLK);
    chk("reset_tcnt", TCNT_Out, 0);
    chk("reset_pulses", {Set_OVF_pulse, Set_UDF_pulse, Set_CMP_pulse}, 0);
    chk("reset_running", running, 0);
    PRESET_n = 1;
    @(negedge PCLK);
    mon_en = 1;

    // 1: free-run up, divide by 4, wrap FF->00 with OVF
    mode = 2'b00; count_up_down = 0; psc_sel = 2; reload_value = 8'hFD; count_enable = 1;
    b = cyc + 1;
    push(b, 8'hFD, 0, 0, 0);   push(b+4, 8'hFE, 0, 0, 0); push(b+8, 8'hFF, 0, 0, 0);
    push(b+12, 8'h00, 1, 0, 0); push(b+16, 8'h01, 0, 0, 0);
    do_load();
    wait_to(b+18); count_enable = 0;
    drain("sc1_drained");

    // 2: auto-reload down from 3, UDF every 4 ticks
    mode = 2'b01; count_up_down = 1; psc_sel = 0; reload_value = 8'h03; count_enable = 1;
    b = cyc + 1;
    push(b, 8'h03, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      push(b+4*k+1, 8'h02, 0, 0, 0); push(b+4*k+2, 8'h01, 0, 0, 0);
      push(b+4*k+3, 8'h00, 0, 0, 0); push(b+4*k+4, 8'h03, 0, 1, 0);
    end
    do_load();
    chk("sc2_running", running, 1);
    wait_to(b+8); count_enable = 0;
    drain("sc2_drained");

    // 3: one-shot up from FE; stops at reload, re-armed by load
    mode = 2'b10; count_up_down = 0; psc_sel = 0; reload_value = 8'hFE; count_enable = 1;
    b = cyc + 1;
    push(b, 8'hFE, 0, 0, 0); push(b+1, 8'hFF, 0, 0, 0); push(b+2, 8'hFE, 1, 0, 0);
    do_load();
    wait_to(b+6);
    chk("sc3_stopped_running", running, 0);
    chk("sc3_hold_tcnt", TCNT_Out, 8'hFE);
    b = cyc + 1;
    push(b+1, 8'hFF, 0, 0, 0); push(b+2, 8'hFE, 1, 0, 0);
    do_load();
    chk("sc3_rearm_running", running, 1);
    wait_to(b+2); count_enable = 0;
    drain("sc3_drained");

    // 4: compare at 00 coincides with OVF; loading 00 raises no CMP
    mode = 2'b00; compare_value = 8'h00; reload_value = 8'hFD; count_enable = 1;
    b = cyc + 1;
    push(b, 8'hFD, 0, 0, 0); push(b+1, 8'hFE, 0, 0, 0); push(b+2, 8'hFF, 0, 0, 0);
    push(b+3, 8'h00, 1, 0, 1); push(b+4, 8'h01, 0, 0, 0);
    do_load();
    wait_to(b+4); count_enable = 0;
    reload_value = 8'h00;
    b = cyc + 1;
    push(b, 8'h00, 0, 0, 0);
    do_load();
    drain("sc4_drained");
    compare_value = 8'h80;

    // 5: enable dropped 10 cycles, then divide by 8 from a cleared prescaler
    psc_sel = 0; reload_value = 8'h10; count_enable = 1;
    b = cyc + 1;
    push(b, 8'h10, 0, 0, 0); push(b+1, 8'h11, 0, 0, 0); push(b+2, 8'h12, 0, 0, 0);
    do_load();
    wait_to(b+2); count_enable = 0;
    wait_to(b+12);
    chk("sc5_hold_tcnt", TCNT_Out, 8'h12);
    r = cyc;
    push(r+8, 8'h13, 0, 0, 0); push(r+16, 8'h14, 0, 0, 0);
    count_enable = 1; psc_sel = 3;
    wait_to(r+16); count_enable = 0;
    drain("sc5_drained");

    // 7: auto-reload up with reload=max: OVF on every tick
    mode = 2'b01; count_up_down = 0; psc_sel = 0; reload_value = 8'hFF; count_enable = 1;
    b = cyc + 1;
    push(b, 8'hFF, 0, 0, 0); push(b+1, 8'hFF, 1, 0, 0); push(b+2, 8'hFF, 1, 0, 0);
    do_load();
    wait_to(b+2); count_enable = 0;
    drain("sc7_drained");

    // 6: reset during a one-shot run just before its OVF
    mode = 2'b10; reload_value = 8'hFE; count_enable = 1;
    b = cyc + 1;
    push(b, 8'hFE, 0, 0, 0); push(b+1, 8'hFF, 0, 0, 0); push(b+2, 8'h00, 0, 0, 0);
    do_load();
    wait_to(b+1); PRESET_n = 0;
    wait_to(b+2);
    chk("sc6_reset_pulses", {Set_OVF_pulse, Set_UDF_pulse, Set_CMP_pulse}, 0);
    chk("sc6_reset_running", running, 0);
    PRESET_n = 1;
    wait_to(b+5);
    chk("sc6_disarmed_tcnt", TCNT_Out, 0);
    chk("sc6_disarmed_running", running, 0);
    count_enable = 0;
    drain("sc6_drained");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
